// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder plus a registered carry, LSB first.
// Operands are loaded in parallel on start, added over WIDTH cycles, and the
// result is presented in parallel together with a one-cycle done pulse.

// One-bit full adder used as the serial datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Pure combinational sum and carry.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands captured on an accepted start
// ADD   | one result bit per cycle, WIDTH cycles in total
// DONE  | single cycle with done high and the result already valid
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    fulladder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; the shift form also covers WIDTH = 1.
    always_comb begin
        psum_next = (psum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    // Sequencer, datapath registers and registered busy/done decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= S_ADD;
                        busy  <= 1'b1;
                    end
                end
                S_ADD: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    psum  <= psum_next;
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= psum_next;
                        cout  <= fa_co;
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH = 8 and WIDTH = 1.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       cin_i;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic       a1;
    logic       b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic       sum1;
    logic       cout1;

    int n_total = 0;
    int n_bad   = 0;

    serial_adder #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .cin   (cin_i),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start at edge k, check busy window, held result, done pulse and result.
    task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           input logic [7:0] exp_s, input logic exp_c,
                           input logic [7:0] prev_s, input logic prev_c);
        a_i = av; b_i = bv; cin_i = cv; start = 1'b1;
        tick;
        start = 1'b0;
        a_i = 8'hC3; b_i = 8'h7E; cin_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("busy_window", busy, 1);
            check("no_early_done", done, 0);
            check("sum_held", sum, prev_s);
            check("cout_held", cout, prev_c);
            tick;
        end
        check("busy_end", busy, 0);
        check("done_pulse", done, 1);
        check("sum", sum, exp_s);
        check("cout", cout, exp_c);
        tick;
        check("done_one_cycle", done, 0);
        check("sum_after", sum, exp_s);
    endtask

    logic [7:0] ra [30];
    logic [7:0] rb [30];
    logic       rc [30];
    logic [1:0] fa_tab [8];
    int         n_done;
    int         exp_edge;
    logic [8:0] exp_full;

    initial begin
        rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 8'h00, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h96, 1'b0);
        run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1);

        // start during ADD is ignored
        a_i = 8'h10; b_i = 8'h20; cin_i = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) begin
                a_i = 8'hFF; b_i = 8'hFF; start = 1'b1;
            end
            tick;
            start = 1'b0;
            if (done) n_done++;
            check("ign_done_timing", done, (c == 8) ? 1 : 0);
            if (c == 8) begin
                check("ign_sum", sum, 8'h30);
                check("ign_cout", cout, 0);
            end
        end
        check("ign_done_count", n_done, 1);

        // reset mid-operation
        a_i = 8'hAA; b_i = 8'h55; cin_i = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_add(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);

        // WIDTH = 1 truth table
        fa_tab[0] = 2'b00; fa_tab[1] = 2'b01; fa_tab[2] = 2'b01; fa_tab[3] = 2'b10;
        fa_tab[4] = 2'b01; fa_tab[5] = 2'b10; fa_tab[6] = 2'b10; fa_tab[7] = 2'b11;
        for (int v = 0; v < 8; v++) begin
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            tick;
            start1 = 1'b0;
            check("w1_busy", busy1, 1);
            check("w1_early_done", done1, 0);
            tick;
            check("w1_done", done1, 1);
            check("w1_result", {cout1, sum1}, fa_tab[v]);
            tick;
            check("w1_done_drop", done1, 0);
        end

        // start held high: one accept every 10 edges
        for (int i = 0; i < 30; i++) begin
            ra[i] = 8'($urandom);
            rb[i] = 8'($urandom);
            rc[i] = 1'($urandom);
        end
        n_done = 0;
        exp_edge = 8;
        for (int i = 0; i < 33; i++) begin
            if (i < 30) begin
                a_i = ra[i]; b_i = rb[i]; cin_i = rc[i]; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick;
            if (done) begin
                n_done++;
                check("b2b_spacing", i, exp_edge);
                if (i >= 8 && i - 8 < 30) begin
                    exp_full = {1'b0, ra[i-8]} + {1'b0, rb[i-8]} + {8'd0, rc[i-8]};
                    check("b2b_result", {cout, sum}, exp_full);
                end
                exp_edge += 10;
            end
        end
        start = 1'b0;
        check("b2b_done_count", n_done, 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder built around the team's existing fulladder module, which serves as its one-bit datapath. A registered carry is fed back into the adder's carry input each cycle, turning the combinational full adder into a WIDTH-bit sequential adder. Operands are loaded in parallel on a start pulse, added LSB-first over WIDTH cycles, and returned as a parallel result with a one-cycle done pulse. It sits downstream of operand registers and upstream of any result consumer; it is a low-area alternative to a ripple-carry array.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is 1 to 32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request to begin an addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on an accepted start
b  input  WIDTH  operand B; captured on an accepted start
cin  input  1  carry-in; captured on an accepted start
busy  output  1  high while an addition is in progress (ADD state)
done  output  1  one-cycle pulse when sum and cout become valid
sum  output  WIDTH  registered result, held until the next completion
cout  output  1  registered carry-out, held until the next completion

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state = IDLE; busy = 0; done = 0; sum = 0; cout = 0.
  - Operand shift registers, carry register, partial-sum register and bit counter all cleared.
- States: IDLE, ADD, DONE. busy = (state == ADD); done = (state == DONE); both are registered decodes with no combinational path from start.
- IDLE:
  - On a clock edge with start = 1: load a_sr <= a, b_sr <= b, carry <= cin, cnt <= 0; go to ADD.
  - Otherwise remain in IDLE.
- ADD, each edge:
  - fulladder inputs are a_sr[0], b_sr[0] and carry.
  - Shift a_sr and b_sr right by one.
  - Shift the sum bit into the MSB of the partial-sum register (right shift).
  - carry <= the adder's carry output; cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1: also write sum <= the completed partial sum (including this bit) and cout <= the final carry, then go to DONE.
- DONE: lasts exactly one cycle (done = 1), then returns to IDLE unconditionally.
- Latency:
  - start is sampled at edge k.
  - busy is high from edge k+1 through edge k+WIDTH.
  - done is high between edge k+WIDTH and edge k+WIDTH+1.
  - The earliest next start is accepted at edge k+WIDTH+2.
  - Throughput is one addition per WIDTH+2 cycles.
- sum and cout change only on completion; they never show partial results.
- start while in ADD or DONE is ignored, with no queuing; a, b and cin may change freely after the accepting edge.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1); unsigned with no overflow flag.
- cnt is $clog2(WIDTH+1) bits wide. WIDTH = 1 is legal: one ADD cycle, then DONE.
- Reset during ADD or DONE aborts the operation: no done pulse, and sum and cout read 0.
- Back-to-back operations: holding start high continuously starts a new addition every WIDTH+2 cycles.

Test Plan:
- WIDTH=8; a=0x5A, b=0x3C, cin=0, start pulsed at edge k -> busy high for 8 cycles; done high for one cycle after edge k+8; sum=0x96, cout=0.
- WIDTH=8; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; the previous result is held until that done.
- WIDTH=8; a=0x10, b=0x20 started; at edge k+3 pulse start with a=0xFF, b=0xFF -> ignored; done at k+8 with sum=0x30, cout=0; only one done pulse.
- WIDTH=8; start a=0xAA, b=0x55; assert rst_n low mid-cycle after edge k+4 -> busy, done, sum and cout drop to 0 immediately; no done after release; a fresh start completes normally with sum=0xFF, cout=0.
- WIDTH=1; all 8 combinations of a, b, cin -> {cout, sum} matches the full-adder truth table (000->00, 001->01, 011->10, 111->11, ...); done arrives 1 cycle after each accepted start.
- WIDTH=8; start held high for 30 cycles with random operands -> exactly 3 done pulses, spaced 10 cycles apart; each result equals a+b+cin as captured at its accepting edge.
